// File: rtl/down_counter_ctl_if.sv
// -----------------------------------------------------------------------------
// down_counter_ctl_if
//   Control/status bundle for the programmable down-counter.
//
//   Control (driven by the master, e.g. software/bench):
//     clr          synchronous clear to IDLE (count=0, reload value kept)
//     load         load load_val into count and the reload register
//     load_val     start / reload value, WIDTH bits
//     en           count enable, one decrement per enabled cycle in RUN
//     auto_reload  1 = periodic mode, 0 = one-shot
//   Status (driven by the counter, all registered):
//     count        current counter value
//     tc           one-cycle terminal-count pulse (first cycle count reads 0)
//     busy         high while in RUN
//     done         high while in DONE (one-shot expired)
// -----------------------------------------------------------------------------
interface down_counter_ctl_if #(
  parameter int WIDTH = 4
) ();

  logic             clr;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             en;
  logic             auto_reload;

  logic [WIDTH-1:0] count;
  logic             tc;
  logic             busy;
  logic             done;

  modport master (
    output clr, load, load_val, en, auto_reload,
    input  count, tc, busy, done
  );

  modport slave (
    input  clr, load, load_val, en, auto_reload,
    output count, tc, busy, done
  );

endinterface : down_counter_ctl_if

// File: rtl/down_counter_ctl.sv
// -----------------------------------------------------------------------------
// down_counter_ctl
//   Programmable loadable down-counter used as an event/interval timer.
//   Software loads a start value; the counter decrements once per enabled
//   cycle and flags expiry with a one-cycle terminal-count pulse. In one-shot
//   mode it parks in DONE at zero; in auto-reload mode it reloads the stored
//   value on the enabled cycle after reaching zero, giving a period of
//   reload_val+1 enabled cycles.
//
//   Ports:
//     clk   rising-edge clock, single domain
//     rst   synchronous, active-high reset
//     bus   down_counter_ctl_if.slave (control inputs, registered status)
//
//   Per-cycle input priority: rst > clr > load > en.
// -----------------------------------------------------------------------------
module down_counter_ctl #(
  parameter int WIDTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  down_counter_ctl_if.slave   bus
);

  // Control FSM encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  // Registered state
  logic [1:0]       state_q;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] reload_q;
  logic             tc_q;
  logic             busy_q;
  logic             done_q;

  // Next-state values
  logic [1:0]       state_d;
  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] reload_d;
  logic             tc_d;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before any branch so no path leaves it
    // unassigned; otherwise synthesis would infer a latch to hold the old value.
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    tc_d     = 1'b0;     // tc is a pulse: low unless this edge produces it

    if (bus.clr) begin
      // Clear abandons the current run but keeps the programmed reload value.
      state_d = ST_IDLE;
      count_d = ZERO;
    end else if (bus.load) begin
      // Load restarts from scratch in any state; a zero load just parks.
      count_d  = bus.load_val;
      reload_d = bus.load_val;
      state_d  = (bus.load_val != ZERO) ? ST_RUN : ST_IDLE;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (bus.en) begin
            if (count_q > ONE) begin
              count_d = count_q - ONE;
            end else if (count_q == ONE) begin
              // Terminal count: the mode is decided by auto_reload right here.
              count_d = ZERO;
              tc_d    = 1'b1;
              state_d = bus.auto_reload ? ST_RUN : ST_DONE;
            end else begin
              // count==0 in RUN only happens in periodic mode after expiry;
              // this enabled cycle is the last of the period and reloads.
              count_d = reload_q;
            end
          end
        end
        ST_DONE: begin
          count_d = ZERO;
        end
        default: begin
          // IDLE (and the unused encoding) hold; en has no effect.
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State registers. busy/done are derived from the next state so they are
  // registered alongside it rather than decoded combinationally afterwards.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (rst) begin
      state_q  <= ST_IDLE;
      count_q  <= ZERO;
      reload_q <= ZERO;
      tc_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
      busy_q   <= (state_d == ST_RUN);
      done_q   <= (state_d == ST_DONE);
    end
  end

  assign bus.count = count_q;
  assign bus.tc    = tc_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

endmodule : down_counter_ctl

// File: tb/tb_down_counter_ctl.sv
// -----------------------------------------------------------------------------
// tb_down_counter_ctl
//   Directed self-checking bench for down_counter_ctl (WIDTH=4). Inputs are
//   changed 1 ns after a rising edge and outputs are sampled at the same
//   point, i.e. away from the active edge.
// -----------------------------------------------------------------------------
module tb_down_counter_ctl;

  localparam int W = 4;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  logic [W+2:0] obs;
  logic [W+2:0] exp_v;

  down_counter_ctl_if #(.WIDTH(W)) bus ();

  down_counter_ctl #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic clr, input logic load, input logic [W-1:0] val,
                       input logic en, input logic ar);
    bus.clr         = clr;
    bus.load        = load;
    bus.load_val    = val;
    bus.en          = en;
    bus.auto_reload = ar;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
    tick();
    tick();
    obs   = {bus.count, bus.tc, bus.busy, bus.done};
    exp_v = {4'd0, 1'b0, 1'b0, 1'b0};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL reset count/tc/busy/done got %0d/%b/%b/%b expected 0/0/0/0",
               bus.count, bus.tc, bus.busy, bus.done);
    end
    rst = 1'b0;
    bus.en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      obs = {bus.count, bus.tc, bus.busy, bus.done};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL idle_en[%0d] count/tc/busy/done got %0d/%b/%b/%b expected 0/0/0/0",
                 i, bus.count, bus.tc, bus.busy, bus.done);
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_one_shot();
    drive(1'b0, 1'b1, 4'd5, 1'b1, 1'b0);
    tick();
    obs   = {bus.count, bus.tc, bus.busy, bus.done};
    exp_v = {4'd5, 1'b0, 1'b1, 1'b0};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL one_shot_load count/tc/busy/done got %0d/%b/%b/%b expected 5/0/1/0",
               bus.count, bus.tc, bus.busy, bus.done);
    end
    bus.load = 1'b0;
    for (int c = 4; c >= 0; c--) begin
      tick();
      obs   = {bus.count, bus.tc, bus.busy, bus.done};
      exp_v = {W'(c), (c == 0), (c != 0), (c == 0)};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL one_shot[%0d] count/tc/busy/done got %0d/%b/%b/%b expected %0d/%b/%b/%b",
                 c, bus.count, bus.tc, bus.busy, bus.done, c, (c == 0), (c != 0), (c == 0));
      end
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      obs   = {bus.count, bus.tc, bus.busy, bus.done};
      exp_v = {4'd0, 1'b0, 1'b0, 1'b1};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL done_hold[%0d] count/tc/busy/done got %0d/%b/%b/%b expected 0/0/0/1",
                 i, bus.count, bus.tc, bus.busy, bus.done);
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_auto_reload();
    logic [W-1:0] exp_cnt [10] = '{4'd3, 4'd2, 4'd1, 4'd0, 4'd3, 4'd2, 4'd1, 4'd0, 4'd3, 4'd2};
    drive(1'b0, 1'b1, 4'd3, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) begin
      tick();
      bus.load = 1'b0;
      obs   = {bus.count, bus.tc, bus.busy, bus.done};
      exp_v = {exp_cnt[i], (exp_cnt[i] == 4'd0), 1'b1, 1'b0};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL auto_reload[%0d] count/tc/busy/done got %0d/%b/%b/%b expected %0d/%b/1/0",
                 i, bus.count, bus.tc, bus.busy, bus.done, exp_cnt[i], (exp_cnt[i] == 4'd0));
      end
    end
  endtask

  // Disabled cycles in periodic mode stretch the period; tc still one cycle.
  task automatic test_auto_stretch();
    logic         en_pat  [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [W-1:0] exp_cnt [6] = '{4'd1, 4'd1, 4'd0, 4'd2, 4'd2, 4'd1};
    logic         exp_tc  [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    drive(1'b0, 1'b1, 4'd2, 1'b0, 1'b1);
    tick();
    bus.load = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.en = en_pat[i];
      tick();
      obs   = {bus.count, bus.tc, bus.busy, bus.done};
      exp_v = {exp_cnt[i], exp_tc[i], 1'b1, 1'b0};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL auto_stretch[%0d] count/tc/busy/done got %0d/%b/%b/%b expected %0d/%b/1/0",
                 i, bus.count, bus.tc, bus.busy, bus.done, exp_cnt[i], exp_tc[i]);
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_en_toggle();
    logic [W-1:0] exp_cnt [9] = '{4'd4, 4'd3, 4'd3, 4'd2, 4'd2, 4'd1, 4'd1, 4'd0, 4'd0};
    logic         exp_tc  [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic         exp_dn  [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    drive(1'b0, 1'b1, 4'd4, 1'b0, 1'b0);
    tick();
    bus.load = 1'b0;
    for (int i = 0; i < 9; i++) begin
      bus.en = (i % 2 == 1);
      tick();
      obs   = {bus.count, bus.tc, bus.busy, bus.done};
      exp_v = {exp_cnt[i], exp_tc[i], ~exp_dn[i], exp_dn[i]};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL en_toggle[%0d] count/tc/busy/done got %0d/%b/%b/%b expected %0d/%b/%b/%b",
                 i, bus.count, bus.tc, bus.busy, bus.done,
                 exp_cnt[i], exp_tc[i], ~exp_dn[i], exp_dn[i]);
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_load_clr_rst();
    // Run 5,4,3,2 then reload 9 mid-period.
    drive(1'b0, 1'b1, 4'd5, 1'b1, 1'b0);
    tick();
    bus.load = 1'b0;
    tick();
    tick();
    tick();
    obs   = {bus.count, bus.tc, bus.busy, bus.done};
    exp_v = {4'd2, 1'b0, 1'b1, 1'b0};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL pre_reload count/tc/busy/done got %0d/%b/%b/%b expected 2/0/1/0",
               bus.count, bus.tc, bus.busy, bus.done);
    end
    drive(1'b0, 1'b1, 4'd9, 1'b1, 1'b0);
    tick();
    obs   = {bus.count, bus.tc, bus.busy, bus.done};
    exp_v = {4'd9, 1'b0, 1'b1, 1'b0};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL mid_reload count/tc/busy/done got %0d/%b/%b/%b expected 9/0/1/0",
               bus.count, bus.tc, bus.busy, bus.done);
    end
    bus.load = 1'b0;
    tick();
    obs   = {bus.count, bus.tc, bus.busy, bus.done};
    exp_v = {4'd8, 1'b0, 1'b1, 1'b0};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL after_reload count/tc/busy/done got %0d/%b/%b/%b expected 8/0/1/0",
               bus.count, bus.tc, bus.busy, bus.done);
    end
    // clr wins over a simultaneous load.
    drive(1'b1, 1'b1, 4'd7, 1'b1, 1'b0);
    tick();
    obs   = {bus.count, bus.tc, bus.busy, bus.done};
    exp_v = {4'd0, 1'b0, 1'b0, 1'b0};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL clr_in_run count/tc/busy/done got %0d/%b/%b/%b expected 0/0/0/0",
               bus.count, bus.tc, bus.busy, bus.done);
    end
    // Reset on the edge that would take count 1->0 and raise tc.
    drive(1'b0, 1'b1, 4'd2, 1'b1, 1'b0);
    tick();
    bus.load = 1'b0;
    tick();
    obs   = {bus.count, bus.tc, bus.busy, bus.done};
    exp_v = {4'd1, 1'b0, 1'b1, 1'b0};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL pre_rst count/tc/busy/done got %0d/%b/%b/%b expected 1/0/1/0",
               bus.count, bus.tc, bus.busy, bus.done);
    end
    rst = 1'b1;
    drive(1'b0, 1'b1, 4'd7, 1'b1, 1'b0);
    tick();
    obs   = {bus.count, bus.tc, bus.busy, bus.done};
    exp_v = {4'd0, 1'b0, 1'b0, 1'b0};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL rst_on_tc count/tc/busy/done got %0d/%b/%b/%b expected 0/0/0/0",
               bus.count, bus.tc, bus.busy, bus.done);
    end
    rst = 1'b0;
    bus.load = 1'b0;
    tick();
    obs = {bus.count, bus.tc, bus.busy, bus.done};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL post_rst_idle count/tc/busy/done got %0d/%b/%b/%b expected 0/0/0/0",
               bus.count, bus.tc, bus.busy, bus.done);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_full_scale();
    int tc_seen;
    tc_seen = 0;
    drive(1'b0, 1'b1, 4'd15, 1'b1, 1'b0);
    tick();
    bus.load = 1'b0;
    obs   = {bus.count, bus.tc, bus.busy, bus.done};
    exp_v = {4'd15, 1'b0, 1'b1, 1'b0};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL full_load count/tc/busy/done got %0d/%b/%b/%b expected 15/0/1/0",
               bus.count, bus.tc, bus.busy, bus.done);
    end
    for (int c = 14; c >= 0; c--) begin
      tick();
      if (bus.tc === 1'b1) tc_seen++;
      checks++;
      if (bus.count !== W'(c)) begin
        errors++;
        $display("FAIL full_count[%0d] count got %0d expected %0d", c, bus.count, c);
      end
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.tc === 1'b1) tc_seen++;
      obs   = {bus.count, bus.tc, bus.busy, bus.done};
      exp_v = {4'd0, 1'b0, 1'b0, 1'b1};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL no_wrap[%0d] count/tc/busy/done got %0d/%b/%b/%b expected 0/0/0/1",
                 i, bus.count, bus.tc, bus.busy, bus.done);
      end
    end
    checks++;
    if (tc_seen !== 1) begin
      errors++;
      $display("FAIL full_tc_count pulses got %0d expected 1", tc_seen);
    end
    // Zero load from DONE parks in IDLE.
    drive(1'b0, 1'b1, 4'd0, 1'b1, 1'b0);
    tick();
    bus.load = 1'b0;
    obs   = {bus.count, bus.tc, bus.busy, bus.done};
    exp_v = {4'd0, 1'b0, 1'b0, 1'b0};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL zero_load count/tc/busy/done got %0d/%b/%b/%b expected 0/0/0/0",
               bus.count, bus.tc, bus.busy, bus.done);
    end
    tick();
    obs = {bus.count, bus.tc, bus.busy, bus.done};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL zero_load_idle count/tc/busy/done got %0d/%b/%b/%b expected 0/0/0/0",
               bus.count, bus.tc, bus.busy, bus.done);
    end
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b1;
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
    test_reset();
    test_one_shot();
    test_auto_reload();
    test_auto_stretch();
    test_en_toggle();
    test_load_clr_rst();
    test_full_scale();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_down_counter_ctl
